// File: rtl/pwm_duty_bank.sv
// Bank of CH double-buffered PWM duty registers: writes land in shadows, and a commit
// moves every shadow into the active set together at the next period boundary.
module pwm_duty_bank #(
    parameter int unsigned CH         = 4,
    parameter int unsigned W          = 8,
    parameter int unsigned MAX_DUTY   = 2**W - 1,
    parameter int unsigned RESET_DUTY = 0,
    localparam int unsigned CW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_ch,
    input  logic [W-1:0]    wr_data,
    input  logic            commit,
    input  logic            period_end,
    output logic [CH*W-1:0] duty,
    output logic            pending,
    output logic            commit_ack,
    output logic            wr_err
);

    localparam logic [W-1:0] MaxW   = W'(MAX_DUTY);
    localparam logic [W-1:0] ResetW = W'(RESET_DUTY);

    typedef enum logic {StIdle, StArmed} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   shadow_q [CH];
    logic [W-1:0]   active_q [CH];
    logic           in_range;
    logic           wr_ok;
    logic           xfer;
    logic [W-1:0]   wr_val;

    always_comb begin
        in_range = 32'(wr_ch) < CH;
        wr_ok    = wr_en && in_range;
        wr_val   = (wr_data > MaxW) ? MaxW : wr_data;
        state_d  = state_q;
        xfer     = 1'b0;
        case (state_q)
            StIdle: begin
                if (commit) begin
                    if (period_end) xfer = 1'b1;
                    else            state_d = StArmed;
                end
            end
            StArmed: begin
                // Extra commits here are absorbed; one boundary serves them all.
                if (period_end) begin
                    xfer    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            commit_ack <= 1'b0;
            wr_err     <= 1'b0;
            for (int k = 0; k < int'(CH); k++) begin
                shadow_q[k] <= ResetW;
                active_q[k] <= ResetW;
            end
        end else begin
            state_q    <= state_d;
            commit_ack <= xfer;
            wr_err     <= wr_en && !in_range;
            if (wr_ok) shadow_q[wr_ch] <= wr_val;
            // Reads pre-edge shadows, so a same-edge write waits for the next transfer.
            if (xfer) begin
                for (int k = 0; k < int'(CH); k++) active_q[k] <= shadow_q[k];
            end
        end
    end

    assign pending = (state_q == StArmed);

    for (genvar k = 0; k < int'(CH); k++) begin : g_duty
        assign duty[k*W +: W] = active_q[k];
    end

endmodule

// File: tb/tb_pwm_duty_bank.sv
// Directed bench for pwm_duty_bank: a CH=4 bank with a clamp and nonzero reset value,
// plus a CH=5 bank so that out-of-range channel writes are encodable.
module tb_pwm_duty_bank;

    logic        ck;
    logic        rst;
    logic        wr_en_a, wr_en_b;
    logic [1:0]  wr_ch_a;
    logic [2:0]  wr_ch_b;
    logic [7:0]  wr_data;
    logic        commit, period_end;
    logic [31:0] duty_a;
    logic [39:0] duty_b;
    logic        pending_a, pending_b, ack_a, ack_b, err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_duty_bank #(.CH(4), .W(8), .MAX_DUTY(200), .RESET_DUTY(5)) dut_a (
        .ck(ck), .rst(rst), .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_data(wr_data),
        .commit(commit), .period_end(period_end), .duty(duty_a), .pending(pending_a),
        .commit_ack(ack_a), .wr_err(err_a)
    );

    pwm_duty_bank #(.CH(5), .W(8)) dut_b (
        .ck(ck), .rst(rst), .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_data(wr_data),
        .commit(commit), .period_end(period_end), .duty(duty_b), .pending(pending_b),
        .commit_ack(ack_b), .wr_err(err_b)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic wr_a(input logic [1:0] ch, input logic [7:0] data);
        wr_en_a = 1'b1;
        wr_ch_a = ch;
        wr_data = data;
        tick();
        wr_en_a = 1'b0;
    endtask

    task automatic wr_b(input logic [2:0] ch, input logic [7:0] data);
        wr_en_b = 1'b1;
        wr_ch_b = ch;
        wr_data = data;
        tick();
        wr_en_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        wr_ch_a = '0; wr_ch_b = '0; wr_data = '0;
        commit = 1'b0; period_end = 1'b0;

        #3;
        check("rst_duty_a", duty_a, {4{8'd5}});
        check("rst_duty_b", duty_b, 40'd0);
        check("rst_pending", pending_a, 1'b0);
        check("rst_ack", ack_a, 1'b0);
        check("rst_err", err_a, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Basic staged update with a five-cycle wait for the boundary
        wr_a(2'd0, 8'd10);
        wr_a(2'd1, 8'd20);
        wr_a(2'd2, 8'd30);
        wr_a(2'd3, 8'd40);
        check("shadow_no_direct", duty_a, {4{8'd5}});
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("armed_pending", pending_a, 1'b1);
            check("armed_duty_hold", duty_a, {4{8'd5}});
            check("armed_no_ack", ack_a, 1'b0);
            if (i == 4) period_end = 1'b1;
            tick();
        end
        period_end = 1'b0;
        check("xfer_duty", duty_a, {8'd40, 8'd30, 8'd20, 8'd10});
        check("xfer_ack", ack_a, 1'b1);
        check("xfer_pending", pending_a, 1'b0);
        tick();
        check("ack_one_cycle", ack_a, 1'b0);

        // Clamp to MAX_DUTY, then same-cycle commit+period_end
        wr_a(2'd2, 8'd255);
        commit = 1'b1; period_end = 1'b1;
        tick();
        commit = 1'b0; period_end = 1'b0;
        check("clamp_duty", duty_a, {8'd40, 8'd200, 8'd20, 8'd10});
        check("clamp_ack", ack_a, 1'b1);
        check("clamp_pending", pending_a, 1'b0);

        // Write concurrent with a transfer lands only in the shadow
        wr_en_a = 1'b1; wr_ch_a = 2'd1; wr_data = 8'd77;
        commit = 1'b1; period_end = 1'b1;
        tick();
        wr_en_a = 1'b0;
        check("same_edge_old", duty_a, {8'd40, 8'd200, 8'd20, 8'd10});
        check("same_edge_ack", ack_a, 1'b1);
        tick();
        commit = 1'b0; period_end = 1'b0;
        check("next_xfer_new", duty_a, {8'd40, 8'd200, 8'd77, 8'd10});

        // period_end without a commit does nothing
        wr_a(2'd3, 8'd99);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("lone_pe_duty", duty_a, {8'd40, 8'd200, 8'd77, 8'd10});
        check("lone_pe_ack", ack_a, 1'b0);
        tick();
        check("lone_pe_ack2", ack_a, 1'b0);

        // Two commits, one transfer
        commit = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        check("dbl_pending", pending_a, 1'b1);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("dbl_duty", duty_a, {8'd99, 8'd200, 8'd77, 8'd10});
        check("dbl_ack", ack_a, 1'b1);
        tick();
        check("dbl_ack_off", ack_a, 1'b0);
        check("dbl_idle", pending_a, 1'b0);
        tick();
        check("dbl_no_second", ack_a, 1'b0);

        // Reset while armed drops the request
        wr_a(2'd0, 8'd123);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("pre_rst_pending", pending_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", duty_a, {4{8'd5}});
        check("async_rst_pending", pending_a, 1'b0);
        tick();
        rst = 1'b0;
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("post_rst_duty", duty_a, {4{8'd5}});
        check("post_rst_pending", pending_a, 1'b0);
        check("post_rst_ack", ack_a, 1'b0);
        commit = 1'b1; period_end = 1'b1;
        tick();
        commit = 1'b0; period_end = 1'b0;
        check("shadow_rst_xfer", duty_a, {4{8'd5}});
        check("shadow_rst_ack", ack_a, 1'b1);

        // First edge after reset release accepts write and commit
        rst = 1'b1;
        #2 rst = 1'b0;
        wr_en_a = 1'b1; wr_ch_a = 2'd0; wr_data = 8'd50; commit = 1'b1;
        tick();
        wr_en_a = 1'b0; commit = 1'b0;
        check("first_edge_pending", pending_a, 1'b1);
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        check("first_edge_duty", duty_a, {8'd5, 8'd5, 8'd5, 8'd50});
        check("first_edge_ack", ack_a, 1'b1);

        // Out-of-range channel on the 5-channel bank
        wr_b(3'd4, 8'd9);
        check("b_valid_no_err", err_b, 1'b0);
        wr_b(3'd5, 8'd77);
        check("b_err_pulse", err_b, 1'b1);
        check("a_never_err", err_a, 1'b0);
        tick();
        check("b_err_one_cycle", err_b, 1'b0);
        wr_b(3'd7, 8'd66);
        check("b_err_pulse7", err_b, 1'b1);
        commit = 1'b1; period_end = 1'b1;
        tick();
        commit = 1'b0; period_end = 1'b0;
        check("b_err_off", err_b, 1'b0);
        check("b_duty_after_err", duty_b, {8'd9, 32'd0});
        check("b_ack", ack_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
